cpu_mem_loader: RTL and testbench
=================================

Name: cpu_mem_loader

Overview:
- Host-side initiator for the CPU's external memory ports; the CPU memories are the responders.
- Loads a word stream into instruction memory and then data memory through the external ports.
- Then runs the CPU for a programmed number of cycles by driving its enable.
- Then reads a data-memory window back out as a word stream.
- Sits beside the cpu block at top level and replaces testbench-only preloading.

Parameters:
DATA_W, 32, word width of streams and memory ports
IMEM_DEPTH, 512, instruction memory depth in words
DMEM_DEPTH, 1024, data memory depth in words
LEN_W, 11, width of all length inputs

Ports:
clk  in  1  main clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle start pulse; ignored unless busy=0
imem_len  in  LEN_W  instruction words to load
dmem_len  in  LEN_W  data words to load
run_cycles  in  32  CPU enable cycles
dump_base  in  LEN_W  first data-memory word index to dump
dump_len  in  LEN_W  words to dump
s_valid  in  1  input stream valid
s_data  in  DATA_W  input stream word
s_ready  out  1  input stream ready
m_valid  out  1  output stream valid
m_data  out  DATA_W  output stream word
m_ready  in  1  output stream ready
cpu_enable  out  1  drives cpu enable
addr_ext  out  32  imem external address (word index, zero-extended)
wen_ext  out  1  imem external write enable
ren_ext  out  1  imem external read enable (tied 0)
wdata_ext  out  DATA_W  imem external write data
addr_ext_2  out  32  dmem external address (word index, zero-extended)
wen_ext_2  out  1  dmem external write enable
ren_ext_2  out  1  dmem external read enable
wdata_ext_2  out  DATA_W  dmem external write data
rdata_ext_2  in  DATA_W  dmem external read data, valid 1 cycle after ren_ext_2
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on entry to IDLE after a completed sequence

Behaviour:
- Reset values: every output is 0. The block enters IDLE. Counters clear.
- Reset mid-operation takes effect at the same edge: strobes and cpu_enable drop, and any held output word is discarded.
- States and transitions:
  - IDLE -> LOAD_I on start.
  - LOAD_I -> LOAD_D -> RUN -> DUMP -> FINISH -> IDLE.
- Skipping: a state whose length or cycle count is 0 is skipped in the same transition. start with all four values 0 goes IDLE -> FINISH -> IDLE, so done pulses 2 cycles after start.
- Lengths are latched at start. imem_len saturates at IMEM_DEPTH and dmem_len at DMEM_DEPTH.
- Dump addresses wrap modulo DMEM_DEPTH. dump_len saturates at DMEM_DEPTH.
- LOAD_I:
  - s_ready=1.
  - Each s_valid&s_ready beat registers wen_ext=1, addr_ext=index, wdata_ext=s_data for exactly the next cycle.
  - Index runs 0..imem_len-1. The final beat moves to the next state.
  - Stalls (s_valid=0) produce wen_ext=0.
- LOAD_D: identical to LOAD_I, on the _2 port.
- Handover: s_ready=0 outside the load states. Excess stream words are not consumed.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles, then 0. The next state follows.
  - No external strobes are driven while cpu_enable=1.
- DUMP:
  - Only one read is outstanding at a time.
  - Cycle 1: ren_ext_2=1 and addr_ext_2=dump_base+k.
  - Cycle 2: rdata_ext_2 is captured into m_data and m_valid=1.
  - m_data/m_valid hold until m_ready. After the handshake, the next read issues on the following cycle.
  - m_ready may be high before m_valid; this does not shorten latency. Minimum throughput is 1 word per 3 cycles.
- FINISH: one cycle. done=1, busy=0 on the next cycle.
- Simultaneous events:
  - start while busy is ignored.
  - rst with start: reset wins.
  - In DUMP, m_ready asserted with no word held is ignored.
- Arithmetic: the cycle counter is 32-bit and counts down. Address counters are LEN_W bits.

Optional Feature:
- Macro LOADER_CSUM_EN.
- With the macro: output port csum (DATA_W).
  - Cleared at start.
  - Adds, modulo 2^DATA_W, every accepted input word and every handshaken output word.
  - Stable from the done pulse until the next start. Reset value 0.
- Without the macro: no port, no adder.

Test Plan:
- Reset: rst=1 for 2 cycles while in LOAD_I -> all outputs 0, state IDLE, s_ready=0.
- Load, run, dump (m_ready=1):
  - Stimulus: imem_len=3, dmem_len=2, words 0xA0..0xA4 streamed back-to-back, run_cycles=5, dump_base=0, dump_len=2.
  - Response: wen_ext at addr 0,1,2 with data 0xA0,0xA1,0xA2; wen_ext_2 at addr 0,1 with data 0xA3,0xA4; cpu_enable high exactly 5 cycles; m_data 0xA3 then 0xA4 (dmem unmodified by CPU); done pulse.
- Backpressure: dump_len=3, m_ready low 4 cycles per word -> m_data held stable, exactly 3 reads issued, no word lost or duplicated.
- Zero and saturation: all lengths 0 -> done 2 cycles after start, no strobes. imem_len=600 -> exactly 512 imem writes, s_ready drops after the 512th.
- Wrap and checksum: dump_base=1022, dump_len=4 -> reads at 1022,1023,0,1. With LOADER_CSUM_EN, inputs 1,2,3 and outputs 1,2 give csum=9.

Source files
------------

// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader
//   Host-side sequencer for the CPU's external memory ports. It streams
//   words into instruction memory and then data memory, enables the CPU for
//   a programmed number of cycles, and streams a data-memory window back
//   out. The CPU memories are the responders on the *_ext ports.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle start pulse, honoured only when idle
//   imem_len, dmem_len       words to load (saturate at the memory depths)
//   run_cycles               CPU enable cycles
//   dump_base, dump_len      data-memory window to read back (wraps)
//   s_valid/s_data/s_ready   input word stream
//   m_valid/m_data/m_ready   output word stream
//   cpu_enable               CPU run enable
//   addr_ext .. wdata_ext    imem external port (ren_ext tied low)
//   addr_ext_2 .. rdata_ext_2 dmem external port, read data 1 cycle late
//   busy, done               status; done pulses once per completed run
//
// Build option
//   LOADER_CSUM_EN adds output csum: running sum of every accepted input
//   word and every delivered output word, cleared at start.

module cpu_mem_loader #(
   parameter int DATA_W     = 32,
   parameter int IMEM_DEPTH = 512,
   parameter int DMEM_DEPTH = 1024,
   parameter int LEN_W      = 11
) (
`ifdef LOADER_CSUM_EN
   output logic [DATA_W-1:0] csum,
`endif
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  imem_len,
   input  logic [LEN_W-1:0]  dmem_len,
   input  logic [31:0]       run_cycles,
   input  logic [LEN_W-1:0]  dump_base,
   input  logic [LEN_W-1:0]  dump_len,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              cpu_enable,
   output logic [31:0]       addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [DATA_W-1:0] wdata_ext,
   output logic [31:0]       addr_ext_2,
   output logic              wen_ext_2,
   output logic              ren_ext_2,
   output logic [DATA_W-1:0] wdata_ext_2,
   input  logic [DATA_W-1:0] rdata_ext_2,
   output logic              busy,
   output logic              done
);

   // state    | meaning
   // S_IDLE   | waiting for start
   // S_LOAD_I | streaming words into imem
   // S_LOAD_D | streaming words into dmem
   // S_RUN    | cpu_enable high for the programmed cycle count
   // S_DUMP   | reading the dmem window out, one read in flight
   // S_FINISH | single cycle before done is pulsed
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP, S_FINISH
   } state_t;

   localparam logic [LEN_W-1:0] IMAX  = LEN_W'(IMEM_DEPTH);
   localparam logic [LEN_W-1:0] DMAX  = LEN_W'(DMEM_DEPTH);
   localparam logic [LEN_W-1:0] DLAST = LEN_W'(DMEM_DEPTH - 1);
   localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    ilen_q, ilen_d, dlen_q, dlen_d, mlen_q, mlen_d;
   logic [LEN_W-1:0]    base_q, base_d, idx_q, idx_d;
   logic [31:0]         run_q, run_d;
   logic                wen_q, wen_d, wen2_q, wen2_d, ren2_q, ren2_d;
   logic [LEN_W-1:0]    addr_q, addr_d, addr2_q, addr2_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d, wdata2_q, wdata2_d;
   logic                m_valid_q, m_valid_d, cap_q, cap_d, done_q, done_d;
   logic [DATA_W-1:0]   m_data_q, m_data_d;
`ifdef LOADER_CSUM_EN
   logic [DATA_W-1:0]   csum_q, csum_d;
`endif

   logic [LEN_W-1:0]    sat_ilen, sat_dlen, sat_mlen, base_wrap;
   logic                issue;

   assign sat_ilen  = (imem_len > IMAX) ? IMAX : imem_len;
   assign sat_dlen  = (dmem_len > DMAX) ? DMAX : dmem_len;
   assign sat_mlen  = (dump_len > DMAX) ? DMAX : dump_len;
   assign base_wrap = (dump_base >= DMAX) ? dump_base - DMAX : dump_base;

   // First phase at or after 'from' that has work to do; empty phases are
   // skipped within the same transition.
   function automatic state_t pick(input state_t from,
                                   input logic [LEN_W-1:0] il,
                                   input logic [LEN_W-1:0] dl,
                                   input logic [31:0] rc,
                                   input logic [LEN_W-1:0] ml);
      pick = S_FINISH;
      if (from <= S_DUMP   && ml != '0) pick = S_DUMP;
      if (from <= S_RUN    && rc != '0) pick = S_RUN;
      if (from <= S_LOAD_D && dl != '0) pick = S_LOAD_D;
      if (from <= S_LOAD_I && il != '0) pick = S_LOAD_I;
   endfunction

   assign busy       = (state_q != S_IDLE);
   assign s_ready    = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
   // The last load strobe may still be on the bus in the first RUN cycle;
   // holding the enable off until it clears keeps the CPU and the loader
   // from touching memory in the same cycle.
   assign cpu_enable = (state_q == S_RUN) && !wen_q && !wen2_q;

   always_comb begin
      state_d   = state_q;
      ilen_d    = ilen_q;
      dlen_d    = dlen_q;
      mlen_d    = mlen_q;
      base_d    = base_q;
      idx_d     = idx_q;
      run_d     = run_q;
      wen_d     = 1'b0;
      wen2_d    = 1'b0;
      ren2_d    = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      addr2_d   = addr2_q;
      wdata2_d  = wdata2_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      cap_d     = 1'b0;
      done_d    = 1'b0;
      issue     = 1'b0;
`ifdef LOADER_CSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ilen_d  = sat_ilen;
               dlen_d  = sat_dlen;
               run_d   = run_cycles;
               mlen_d  = sat_mlen;
               base_d  = base_wrap;
               state_d = pick(S_LOAD_I, sat_ilen, sat_dlen, run_cycles, sat_mlen);
               idx_d   = (state_d == S_DUMP) ? base_wrap : '0;
`ifdef LOADER_CSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_LOAD_I: begin
            if (s_valid) begin
               wen_d   = 1'b1;
               addr_d  = idx_q;
               wdata_d = s_data;
               idx_d   = idx_q + ONE;
               ilen_d  = ilen_q - ONE;
`ifdef LOADER_CSUM_EN
               csum_d  = csum_q + s_data;
`endif
               if (ilen_q == ONE) begin
                  state_d = pick(S_LOAD_D, ilen_q, dlen_q, run_q, mlen_q);
                  idx_d   = (state_d == S_DUMP) ? base_q : '0;
               end
            end
         end
         S_LOAD_D: begin
            if (s_valid) begin
               wen2_d   = 1'b1;
               addr2_d  = idx_q;
               wdata2_d = s_data;
               idx_d    = idx_q + ONE;
               dlen_d   = dlen_q - ONE;
`ifdef LOADER_CSUM_EN
               csum_d   = csum_q + s_data;
`endif
               if (dlen_q == ONE) begin
                  state_d = pick(S_RUN, ilen_q, dlen_q, run_q, mlen_q);
                  idx_d   = (state_d == S_DUMP) ? base_q : '0;
               end
            end
         end
         S_RUN: begin
            if (cpu_enable) begin
               run_d = run_q - 32'd1;
               if (run_q == 32'd1) begin
                  state_d = pick(S_DUMP, ilen_q, dlen_q, run_q, mlen_q);
                  idx_d   = base_q;
               end
            end
         end
         S_DUMP: begin
            cap_d = ren2_q;
            if (cap_q) begin
               m_valid_d = 1'b1;
               m_data_d  = rdata_ext_2;
            end
            // Nothing in flight and nothing held: only true on DUMP entry.
            if (!ren2_q && !cap_q && !m_valid_q) begin
               issue = 1'b1;
            end else if (m_valid_q && m_ready) begin
               m_valid_d = 1'b0;
               mlen_d    = mlen_q - ONE;
`ifdef LOADER_CSUM_EN
               csum_d    = csum_q + m_data_q;
`endif
               if (mlen_q == ONE) state_d = S_FINISH;
               else               issue   = 1'b1;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (issue) begin
         ren2_d  = 1'b1;
         addr2_d = idx_q;
         idx_d   = (idx_q == DLAST) ? '0 : idx_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ilen_q    <= '0;
         dlen_q    <= '0;
         mlen_q    <= '0;
         base_q    <= '0;
         idx_q     <= '0;
         run_q     <= '0;
         wen_q     <= 1'b0;
         wen2_q    <= 1'b0;
         ren2_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         addr2_q   <= '0;
         wdata2_q  <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         cap_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef LOADER_CSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ilen_q    <= ilen_d;
         dlen_q    <= dlen_d;
         mlen_q    <= mlen_d;
         base_q    <= base_d;
         idx_q     <= idx_d;
         run_q     <= run_d;
         wen_q     <= wen_d;
         wen2_q    <= wen2_d;
         ren2_q    <= ren2_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         addr2_q   <= addr2_d;
         wdata2_q  <= wdata2_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         cap_q     <= cap_d;
         done_q    <= done_d;
`ifdef LOADER_CSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign addr_ext    = {{(32-LEN_W){1'b0}}, addr_q};
   assign wen_ext     = wen_q;
   assign ren_ext     = 1'b0;
   assign wdata_ext   = wdata_q;
   assign addr_ext_2  = {{(32-LEN_W){1'b0}}, addr2_q};
   assign wen_ext_2   = wen2_q;
   assign ren_ext_2   = ren2_q;
   assign wdata_ext_2 = wdata2_q;
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign done        = done_q;
`ifdef LOADER_CSUM_EN
   assign csum        = csum_q;
`endif

endmodule

// File: tb/tb_cpu_mem_loader.sv
module tb_cpu_mem_loader;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 11;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  imem_len = '0, dmem_len = '0, dump_base = '0, dump_len = '0;
   logic [31:0]       run_cycles = '0;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_ready, m_valid, m_ready = 1'b0;
   logic [DATA_W-1:0] m_data;
   logic              cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
   logic [31:0]       addr_ext, addr_ext_2;
   logic [DATA_W-1:0] wdata_ext, wdata_ext_2, rdata_ext_2;
`ifdef LOADER_CSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   cpu_mem_loader dut (
`ifdef LOADER_CSUM_EN
      .csum(csum),
`endif
      .clk(clk), .rst(rst), .start(start),
      .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles),
      .dump_base(dump_base), .dump_len(dump_len),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .cpu_enable(cpu_enable),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // data-memory responder, preset to D000_0000 | index
   logic [DATA_W-1:0] dmem [1024];
   bit dmem_init;
   always @(posedge clk) begin
      if (!dmem_init) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= 32'hD000_0000 | i;
         dmem_init <= 1'b1;
      end else if (wen_ext_2) begin
         dmem[addr_ext_2[9:0]] <= wdata_ext_2;
      end
      if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[9:0]];
   end

   logic [168:0] outs_all;
   assign outs_all = {s_ready, m_valid, m_data, cpu_enable, addr_ext, wen_ext, ren_ext,
                      wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, done};

   // monitor: logs bus activity, sampled mid-cycle
   logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], rd_a[$], mo_d[$];
   int n_en, n_rise, n_viol, n_done, done_cyc, n_stab;
   logic prev_en = 1'b0, prev_hold = 1'b0;
   logic [31:0] prev_md = '0;
   always @(negedge clk) begin
      #2;
      if (wen_ext)   begin iw_a.push_back(addr_ext);   iw_d.push_back(wdata_ext);   end
      if (wen_ext_2) begin dw_a.push_back(addr_ext_2); dw_d.push_back(wdata_ext_2); end
      if (ren_ext_2) rd_a.push_back(addr_ext_2);
      if (cpu_enable) n_en++;
      if (cpu_enable && !prev_en) n_rise++;
      if (cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2 || ren_ext)) n_viol++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (prev_hold && (!m_valid || m_data !== prev_md)) n_stab++;
      if (m_valid && m_ready) mo_d.push_back(m_data);
      prev_en   = cpu_enable;
      prev_hold = m_valid && !m_ready;
      prev_md   = m_data;
   end

   int n_pass = 0, n_total = 0;
   int s_iw, s_dw, s_rd, s_mo, s_en, s_rise, s_viol, s_done, s_stab, start_cyc;

   task automatic snap();
      @(negedge clk);
      s_iw = iw_a.size(); s_dw = dw_a.size(); s_rd = rd_a.size(); s_mo = mo_d.size();
      s_en = n_en; s_rise = n_rise; s_viol = n_viol; s_done = n_done; s_stab = n_stab;
   endtask

   task automatic kick(input int il, input int dl, input logic [31:0] rc,
                       input int db, input int ml);
      @(negedge clk);
      imem_len = LEN_W'(il); dmem_len = LEN_W'(dl); run_cycles = rc;
      dump_base = LEN_W'(db); dump_len = LEN_W'(ml);
      start = 1'b1; start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic stream(input int n, input logic [31:0] first, input int max_cyc,
                         output int acc);
      int c = 0;
      acc = 0;
      while (acc < n && c < max_cyc) begin
         @(negedge clk);
         s_valid = 1'b1; s_data = first + acc;
         if (s_ready) acc++;
         c++;
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int max_cyc);
      int c = 0;
      logic seen = 1'b0;
      while (c < max_cyc && !seen) begin
         @(negedge clk); #2;
         seen = done;
         c++;
      end
      n_total++;
      if (!seen) $display("FAIL %s: done not seen within %0d cycles", nm, max_cyc);
      else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_total++;
      if (outs_all !== '0) $display("FAIL reset_outputs: got %h required 0", outs_all);
      else n_pass++;
      kick(5, 0, 0, 0, 0);
      @(negedge clk); s_valid = 1'b1; s_data = 32'h11;
      @(negedge clk); s_data = 32'h12;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (outs_all !== '0) $display("FAIL reset_mid_load1: got %h required 0", outs_all);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (outs_all !== '0) $display("FAIL reset_mid_load2: got %h required 0", outs_all);
      else n_pass++;
      rst = 1'b0; s_valid = 1'b0;
      imem_len = LEN_W'(3);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || s_ready !== 1'b0)
         $display("FAIL reset_beats_start: busy=%b s_ready=%b required 0 0", busy, s_ready);
      else n_pass++;
   endtask

   task automatic test_load_run_dump();
      int acc;
      snap();
      m_ready = 1'b1;
      kick(3, 2, 5, 0, 2);
      stream(5, 32'hA0, 50, acc);
      wait_done("flow_done", 300);
      n_total++;
      if (acc != 5 || iw_a.size() - s_iw != 3 || dw_a.size() - s_dw != 2)
         $display("FAIL flow_counts: acc=%0d imem_wr=%0d dmem_wr=%0d required 5 3 2",
                  acc, iw_a.size() - s_iw, dw_a.size() - s_dw);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (iw_a[s_iw+i] !== 32'(i) || iw_d[s_iw+i] !== 32'hA0 + 32'(i))
            $display("FAIL flow_imem%0d: addr=%0h data=%h required %0h %h", i,
                     iw_a[s_iw+i], iw_d[s_iw+i], i, 32'hA0 + 32'(i));
         else n_pass++;
      end
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (dw_a[s_dw+i] !== 32'(i) || dw_d[s_dw+i] !== 32'hA3 + 32'(i))
            $display("FAIL flow_dmem%0d: addr=%0h data=%h required %0h %h", i,
                     dw_a[s_dw+i], dw_d[s_dw+i], i, 32'hA3 + 32'(i));
         else n_pass++;
      end
      n_total++;
      if (n_en - s_en != 5 || n_rise - s_rise != 1 || n_viol != s_viol)
         $display("FAIL flow_enable: cycles=%0d bursts=%0d overlaps=%0d required 5 1 0",
                  n_en - s_en, n_rise - s_rise, n_viol - s_viol);
      else n_pass++;
      n_total++;
      if (rd_a.size() - s_rd != 2 || rd_a[s_rd] !== 32'd0 || rd_a[s_rd+1] !== 32'd1)
         $display("FAIL flow_reads: count=%0d required 2 at 0,1", rd_a.size() - s_rd);
      else n_pass++;
      n_total++;
      if (mo_d.size() - s_mo != 2 || mo_d[s_mo] !== 32'hA3 || mo_d[s_mo+1] !== 32'hA4)
         $display("FAIL flow_dump: count=%0d first=%h second=%h required 2 a3 a4",
                  mo_d.size() - s_mo, mo_d[s_mo], mo_d[s_mo+1]);
      else n_pass++;
      n_total++;
      if (n_done - s_done != 1 || busy !== 1'b0)
         $display("FAIL flow_done_pulse: pulses=%0d busy=%b required 1 0", n_done - s_done, busy);
      else n_pass++;
      m_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_d [3];
      exp_d[0] = 32'hA3; exp_d[1] = 32'hA4; exp_d[2] = 32'hD000_0002;
      snap();
      m_ready = 1'b0;
      kick(0, 0, 0, 0, 3);
      for (int w = 0; w < 3; w++) begin
         int g = 0;
         while (!m_valid && g < 50) begin @(negedge clk); g++; end
         for (int i = 0; i < 4; i++) begin
            // a start while busy must be ignored
            if (w == 1 && i == 0) begin imem_len = LEN_W'(5); start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
         end
         start = 1'b0;
         m_ready = 1'b1;
         @(negedge clk);
         m_ready = 1'b0;
      end
      wait_done("bp_done", 100);
      n_total++;
      if (rd_a.size() - s_rd != 3 || mo_d.size() - s_mo != 3)
         $display("FAIL bp_counts: reads=%0d words=%0d required 3 3",
                  rd_a.size() - s_rd, mo_d.size() - s_mo);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (rd_a[s_rd+i] !== 32'(i) || mo_d[s_mo+i] !== exp_d[i])
            $display("FAIL bp_word%0d: addr=%0h data=%h required %0h %h", i,
                     rd_a[s_rd+i], mo_d[s_mo+i], i, exp_d[i]);
         else n_pass++;
      end
      n_total++;
      if (n_stab != s_stab) $display("FAIL bp_hold: unstable=%0d required 0", n_stab - s_stab);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0 || iw_a.size() != s_iw)
         $display("FAIL bp_start_ignored: busy=%b imem_wr=%0d required 0 0",
                  busy, iw_a.size() - s_iw);
      else n_pass++;
   endtask

   task automatic test_zero_sat();
      int acc;
      snap();
      kick(0, 0, 0, 0, 0);
      wait_done("zero_done", 20);
      n_total++;
      if (done_cyc - start_cyc != 2)
         $display("FAIL zero_latency: got %0d cycles required 2", done_cyc - start_cyc);
      else n_pass++;
      n_total++;
      if (iw_a.size() != s_iw || dw_a.size() != s_dw || rd_a.size() != s_rd || n_en != s_en)
         $display("FAIL zero_strobes: imem=%0d dmem=%0d reads=%0d en=%0d required 0",
                  iw_a.size() - s_iw, dw_a.size() - s_dw, rd_a.size() - s_rd, n_en - s_en);
      else n_pass++;
      snap();
      kick(600, 0, 0, 0, 0);
      stream(600, 32'h1000, 600, acc);
      repeat (3) @(negedge clk);
      n_total++;
      if (acc != 512 || iw_a.size() - s_iw != 512)
         $display("FAIL sat_count: accepted=%0d writes=%0d required 512 512",
                  acc, iw_a.size() - s_iw);
      else n_pass++;
      n_total++;
      if (iw_a[s_iw+511] !== 32'd511 || iw_d[s_iw+511] !== 32'h11FF || iw_a[s_iw] !== 32'd0)
         $display("FAIL sat_last: addr=%0d data=%h required 511 11ff",
                  iw_a[s_iw+511], iw_d[s_iw+511]);
      else n_pass++;
      n_total++;
      if (s_ready !== 1'b0 || busy !== 1'b0 || n_done - s_done != 1)
         $display("FAIL sat_end: s_ready=%b busy=%b pulses=%0d required 0 0 1",
                  s_ready, busy, n_done - s_done);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a [4];
      logic [31:0] exp_d [4];
      exp_a[0] = 32'd1022; exp_a[1] = 32'd1023; exp_a[2] = 32'd0; exp_a[3] = 32'd1;
      exp_d[0] = 32'hD000_03FE; exp_d[1] = 32'hD000_03FF; exp_d[2] = 32'hA3; exp_d[3] = 32'hA4;
      snap();
      m_ready = 1'b1;
      kick(0, 0, 0, 1022, 4);
      wait_done("wrap_done", 100);
      n_total++;
      if (rd_a.size() - s_rd != 4) $display("FAIL wrap_count: got %0d required 4", rd_a.size() - s_rd);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (rd_a[s_rd+i] !== exp_a[i] || mo_d[s_mo+i] !== exp_d[i])
            $display("FAIL wrap_word%0d: addr=%0d data=%h required %0d %h", i,
                     rd_a[s_rd+i], mo_d[s_mo+i], exp_a[i], exp_d[i]);
         else n_pass++;
      end
      m_ready = 1'b0;
   endtask

`ifdef LOADER_CSUM_EN
   task automatic test_csum();
      int acc;
      m_ready = 1'b1;
      kick(0, 3, 0, 0, 2);
      stream(3, 32'd1, 20, acc);
      wait_done("csum_done", 100);
      n_total++;
      if (csum !== 32'd9) $display("FAIL csum_value: got %0d required 9", csum);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_total++;
      if (csum !== 32'd9) $display("FAIL csum_stable: got %0d required 9", csum);
      else n_pass++;
      m_ready = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_load_run_dump();
      test_backpressure();
      test_zero_sat();
      test_wrap();
`ifdef LOADER_CSUM_EN
      test_csum();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
